// File: rtl/fetch_queue.sv
// fetch_queue: pipelined instruction fetch front end.
//   Issues at most one request per cycle to a synchronous instruction memory
//   with a 1-cycle read latency. Returned words are buffered in a DEPTH-entry
//   queue and handed to decode over a valid/ready handshake. Control-flow
//   resolutions from execute redirect the PC and flush all wrong-path state.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start_address       PC loaded while reset is high
//   imem_req/imem_addr  memory read request and address (bit-reversed if BIT_REVERSE)
//   imem_data           read data for the previous cycle's request
//   out_valid/out_ready head-of-queue handshake to decode
//   out_instr           head instruction (LSB-first)
//   out_pc_plus4        PC + 4 of the head instruction
//   res_*               control-flow resolution from execute
//   redirect            resolution taken this cycle (for upstream squash)
module fetch_queue #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned JVAL_W      = 26,
   parameter int unsigned BIT_REVERSE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   start_address,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic [XLEN-1:0]   imem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_instr,
   output logic [XLEN-1:0]   out_pc_plus4,
   input  logic              res_valid,
   input  logic              res_beqz,
   input  logic              res_bnez,
   input  logic              res_jump,
   input  logic              res_jump_reg,
   input  logic              res_zflag,
   input  logic              res_nzflag,
   input  logic [XLEN-1:0]   res_pc_plus4,
   input  logic [XLEN-1:0]   res_imm,
   input  logic [JVAL_W-1:0] res_jval,
   input  logic [XLEN-1:0]   res_reg_s1,
   output logic              redirect
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   function automatic logic [XLEN-1:0] bitRev(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
      return r;
   endfunction

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] issuedPcPlus4;
   logic [CW-1:0]   count;
   logic            inflight;
   logic            inflightEpoch;
   logic            epoch;
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [XLEN-1:0] instrQ [DEPTH];
   logic [XLEN-1:0] tagQ   [DEPTH];

   logic            takenBr;
   logic [XLEN-1:0] jumpTarget;
   logic [XLEN-1:0] branchTarget;
   logic [XLEN-1:0] target;
   logic            issue;
   logic            enq;
   logic            deq;
   logic [XLEN-1:0] respInstr;

   // Resolution and redirect target
   always_comb begin
      takenBr      = (res_zflag & res_beqz) | (res_nzflag & res_bnez);
      jumpTarget   = res_jump_reg ? res_reg_s1
                                  : {{(XLEN-JVAL_W){res_jval[JVAL_W-1]}}, res_jval};
      branchTarget = res_pc_plus4 + (res_imm << 2);
      target       = res_jump ? jumpTarget : branchTarget;
      redirect     = ~reset & res_valid & (res_jump | takenBr);
   end

   // In-flight requests count against capacity so a response always has a slot.
   always_comb begin
      issue = ~reset & ~redirect &
              (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
      // A response is kept only if no redirect happened since its request left.
      enq   = inflight & (inflightEpoch == epoch);
      deq   = out_valid & out_ready;
   end

   assign respInstr    = (BIT_REVERSE != 0) ? bitRev(imem_data) : imem_data;
   assign imem_req     = issue;
   assign imem_addr    = (BIT_REVERSE != 0) ? bitRev(pc) : pc;
   assign out_valid    = ~reset & (count != '0);
   assign out_instr    = instrQ[head];
   assign out_pc_plus4 = tagQ[head];

   always_ff @(posedge clk) begin
      if (reset) begin
         pc            <= start_address;
         count         <= '0;
         inflight      <= 1'b0;
         inflightEpoch <= 1'b0;
         epoch         <= 1'b0;
         head          <= '0;
         tail          <= '0;
      end else begin
         inflight      <= issue;
         inflightEpoch <= epoch;
         if (issue) begin
            pc            <= pc + XLEN'(4);
            issuedPcPlus4 <= pc + XLEN'(4);
         end
         if (redirect) begin
            // Head handshake this cycle is honoured by simply dropping everything.
            pc    <= target;
            count <= '0;
            head  <= '0;
            tail  <= '0;
            epoch <= ~epoch;
         end else begin
            if (enq) tail <= tail + AW'(1);
            if (deq) head <= head + AW'(1);
            case ({enq, deq})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Queue storage needs no reset; occupancy alone qualifies it.
   always_ff @(posedge clk) begin
      if (!reset && !redirect && enq) begin
         instrQ[tail] <= respInstr;
         tagQ[tail]   <= issuedPcPlus4;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] start_address;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;
   logic        res_valid, res_beqz, res_bnez, res_jump, res_jump_reg;
   logic        res_zflag, res_nzflag;
   logic [31:0] res_pc_plus4, res_imm, res_reg_s1;
   logic [25:0] res_jval;
   logic        redirect;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   fetch_queue #(.XLEN(32), .DEPTH(4), .JVAL_W(26), .BIT_REVERSE(1)) dut (
      .clk(clk), .reset(reset), .start_address(start_address),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc_plus4(out_pc_plus4),
      .res_valid(res_valid), .res_beqz(res_beqz), .res_bnez(res_bnez),
      .res_jump(res_jump), .res_jump_reg(res_jump_reg),
      .res_zflag(res_zflag), .res_nzflag(res_nzflag),
      .res_pc_plus4(res_pc_plus4), .res_imm(res_imm), .res_jval(res_jval),
      .res_reg_s1(res_reg_s1), .redirect(redirect)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // Program image: a bijective scramble of the word address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   // MSB-first synchronous memory, 1-cycle latency.
   always @(posedge clk)
      imem_data <= imem_req ? rev32(memWord(rev32(imem_addr))) : $urandom();

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the fetch stream as an address sequence.
   logic [31:0] mIssuePc, mNextPc;
   int          mOutstanding;   // issued on current path, not yet delivered
   int          mLastIssued;    // issued in the previous cycle (still in memory)

   initial begin
      bit          take;
      bit          expReq, expValid;
      logic [31:0] tgt;
      mIssuePc = '0; mNextPc = '0; mOutstanding = 0; mLastIssued = 0;
      forever begin
         @(negedge clk);
         #3;
         if (reset) begin
            check("rstReq", {31'b0, imem_req}, 32'd0);
            check("rstValid", {31'b0, out_valid}, 32'd0);
            check("rstRedirect", {31'b0, redirect}, 32'd0);
            mIssuePc = start_address; mNextPc = start_address;
            mOutstanding = 0; mLastIssued = 0;
         end else begin
            take = 0; tgt = '0;
            if (res_valid && res_jump) begin
               take = 1;
               tgt  = res_jump_reg ? res_reg_s1 : {{6{res_jval[25]}}, res_jval};
            end else if (res_valid && ((res_beqz && res_zflag) || (res_bnez && res_nzflag))) begin
               take = 1;
               tgt  = res_pc_plus4 + res_imm * 4;
            end
            expValid = (mOutstanding - mLastIssued) > 0;
            expReq   = !take && (mOutstanding < 4);
            check("redirect", {31'b0, redirect}, {31'b0, take});
            check("outValid", {31'b0, out_valid}, {31'b0, expValid});
            check("imemReq", {31'b0, imem_req}, {31'b0, expReq});
            if (expReq) check("imemAddr", rev32(imem_addr), mIssuePc);
            if (expValid && out_ready) begin
               check("outPcPlus4", out_pc_plus4, mNextPc + 32'd4);
               check("outInstr", out_instr, memWord(mNextPc));
               mNextPc = mNextPc + 32'd4;
               mOutstanding--;
            end
            if (expReq) begin
               mIssuePc = mIssuePc + 32'd4;
               mOutstanding++;
            end
            mLastIssued = expReq ? 1 : 0;
            if (take) begin
               mIssuePc = tgt; mNextPc = tgt;
               mOutstanding = 0; mLastIssued = 0;
            end
         end
      end
   end

   typedef struct {
      logic        beqz, bnez, jump, jumpReg, zflag, nzflag;
      logic [31:0] pcPlus4, imm;
      logic [25:0] jval;
      logic [31:0] regS1;
      logic        expRedirect;
      logic [31:0] expTarget;
   } resVec_t;

   resVec_t tbl [8];

   task automatic clearRes();
      res_valid = 1'b0; res_beqz = 1'b0; res_bnez = 1'b0; res_jump = 1'b0;
      res_jump_reg = 1'b0; res_zflag = 1'b0; res_nzflag = 1'b0;
      res_pc_plus4 = '0; res_imm = '0; res_jval = '0; res_reg_s1 = '0;
   endtask

   task automatic doReset(input logic [31:0] addr, input int cycles);
      @(negedge clk);
      reset = 1'b1; start_address = addr;
      repeat (cycles - 1) @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int reqs;
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200,  32'hFFFFFFFE, 26'h0,       32'h0,    1'b1, 32'h1F8};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        26'h0,       32'h4000, 1'b1, 32'h4000};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        26'h3FFFFFC, 32'h0,    1'b1, 32'hFFFFFFFC};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300,  32'h10,       26'h0,       32'h0,    1'b0, 32'h0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300,  32'h10,       26'h0,       32'h0,    1'b0, 32'h0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h3,        26'h0,       32'h0,    1'b1, 32'h100C};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,    32'h0,        26'h10,      32'h0,    1'b1, 32'h10};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500,  32'h7,        26'h5,       32'h9000, 1'b0, 32'h0};

      clearRes();
      reset = 1'b1; start_address = 32'h100; out_ready = 1'b1;

      // Fill and steady stream from 0x100
      doReset(32'h100, 2);
      for (int i = 0; i < 3; i++) begin
         #3;
         check("fillReq", {31'b0, imem_req}, 32'd1);
         check("fillAddr", rev32(imem_addr), 32'h100 + 32'(4 * i));
         if (i == 2) check("fillPcPlus4", out_pc_plus4, 32'h104);
         @(negedge clk);
      end

      // Back-pressure: exactly DEPTH requests, then in-order drain
      doReset(32'h300, 2);
      out_ready = 1'b0;
      reqs = 0;
      for (int i = 0; i < 10; i++) begin
         #3;
         if (imem_req) reqs++;
         @(negedge clk);
      end
      #3;
      check("stallReqCount", 32'(reqs), 32'd4);
      check("stallReqLow", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #3;
         check("drainValid", {31'b0, out_valid}, 32'd1);
         check("drainPcPlus4", out_pc_plus4, 32'h304 + 32'(4 * i));
         @(negedge clk);
      end

      // Resolution table
      for (int i = 0; i < 8; i++) begin
         res_valid = 1'b1;
         res_beqz = tbl[i].beqz; res_bnez = tbl[i].bnez;
         res_jump = tbl[i].jump; res_jump_reg = tbl[i].jumpReg;
         res_zflag = tbl[i].zflag; res_nzflag = tbl[i].nzflag;
         res_pc_plus4 = tbl[i].pcPlus4; res_imm = tbl[i].imm;
         res_jval = tbl[i].jval; res_reg_s1 = tbl[i].regS1;
         #3;
         check("tblRedirect", {31'b0, redirect}, {31'b0, tbl[i].expRedirect});
         @(negedge clk);
         clearRes();
         #3;
         if (tbl[i].expRedirect) begin
            check("tblTargetReq", {31'b0, imem_req}, 32'd1);
            check("tblTarget", rev32(imem_addr), tbl[i].expTarget);
         end
         @(negedge clk);
      end

      // PC wrap through 0xFFFFFFFC
      res_valid = 1'b1; res_jump = 1'b1; res_jval = 26'h3FFFFFC;
      @(negedge clk);
      clearRes();
      #3;
      check("wrapAddr0", rev32(imem_addr), 32'hFFFFFFFC);
      @(negedge clk);
      #3;
      check("wrapAddr1", rev32(imem_addr), 32'h0);
      @(negedge clk);

      // Reset mid-operation with a request in flight
      doReset(32'h8, 2);
      out_ready = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1; start_address = 32'h4;
      @(negedge clk);
      reset = 1'b0;
      #3;
      check("rstMidValid", {31'b0, out_valid}, 32'd0);
      check("rstMidReq", {31'b0, imem_req}, 32'd1);
      check("rstMidRawAddr", imem_addr, 32'h20000000);
      @(negedge clk);
      out_ready = 1'b1;

      // Randomised traffic, checked by the reference model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         if (reset) start_address = $urandom() & 32'hFFFFFFFC;
         out_ready = ($urandom_range(0, 9) < 7);
         res_valid = ($urandom_range(0, 9) == 0);
         res_beqz = 1'($urandom()); res_bnez = 1'($urandom());
         res_jump = ($urandom_range(0, 3) == 0); res_jump_reg = 1'($urandom());
         res_zflag = 1'($urandom()); res_nzflag = 1'($urandom());
         res_pc_plus4 = $urandom();
         res_imm = 32'($urandom_range(0, 63)) - 32'd32;
         res_jval = 26'($urandom());
         res_reg_s1 = $urandom();
      end
      @(negedge clk);
      clearRes(); reset = 1'b0;
      repeat (3) @(negedge clk);
      #4;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Pipelined, parametrised successor to the single-cycle fetch unit.
- Issues one instruction-memory request per cycle to a synchronous memory with 1-cycle read latency.
- Buffers returned instructions in a DEPTH-entry queue, delivered to decode over a valid/ready handshake.
- Resolves BEQZ/BNEZ/J/JR redirects arriving from execute, flushing all wrong-path state.

Parameters:
- XLEN, 32, width of PC, instruction, immediate and register operands.
- DEPTH, 4, instruction queue entries (power of two, min 2).
- JVAL_W, 26, width of the jump value field, sign-extended to XLEN.
- BIT_REVERSE, 1, when 1, imem_addr and imem_data are bit-reversed at the memory boundary (memory is MSB-first).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start_address  input  XLEN  PC loaded while reset is high
- imem_req  output  1  read request this cycle
- imem_addr  output  XLEN  read address, bit-reversed if BIT_REVERSE
- imem_data  input  XLEN  read data for the previous cycle's request
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_instr  output  XLEN  head instruction, LSB-first
- out_pc_plus4  output  XLEN  head PC + 4
- res_valid  input  1  execute presents a control-flow resolution
- res_beqz, res_bnez, res_jump, res_jump_reg  input  1 each  instruction class
- res_zflag, res_nzflag  input  1 each  condition flags
- res_pc_plus4  input  XLEN  PC + 4 of the resolving instruction
- res_imm  input  XLEN  sign-extended branch immediate
- res_jval  input  JVAL_W  jump value field
- res_reg_s1  input  XLEN  register operand for JR
- redirect  output  1  redirect taken this cycle (for upstream squash)

Behaviour:
- Reset:
  - pc <= start_address; queue count = 0; in-flight flag = 0.
  - out_valid = 0, imem_req = 0, redirect = 0.
- Issue:
  - imem_req = 1 when not in reset and (count + inflight) < DEPTH.
  - imem_addr = pc; pc <= pc + 4 on issue (mod 2^XLEN, carry ignored).
- Response:
  - The cycle after an issue, imem_data is written to the queue tail with the tag pc_issued + 4, unless squashed.
- Dequeue:
  - On out_valid && out_ready, the head is removed.
  - Enqueue and dequeue in the same cycle leave count unchanged; both are permitted when full.
- Full:
  - Issue stops; no response is ever dropped for lack of space, because in-flight requests are counted.
- Empty:
  - out_valid = 0; out_instr and out_pc_plus4 are don't-care.
- Resolution (combinational from res_* when res_valid):
  - taken_br = (res_zflag & res_beqz) | (res_nzflag & res_bnez).
  - Jump target = res_jump_reg ? res_reg_s1 : sign-extended res_jval.
  - Branch target = res_pc_plus4 + (res_imm << 2).
  - If res_jump, use the jump target; else if taken_br, use the branch target.
  - redirect = res_valid & (res_jump | taken_br).
- Redirect effects, on the next edge:
  - pc <= target; queue flushed (count = 0); in-flight response squashed via an epoch bit.
  - No request is issued in the redirect cycle.
  - The first new-path request issues in the following cycle.
  - A head handshake in the same cycle as redirect completes, and that instruction is consumed. All other entries are discarded.
- Not-taken resolution: no effect.
- Reset overrides redirect and all in-flight state, including mid-operation.
- Latency: redirect edge -> request at +1 -> out_valid at +2.

Test Plan:
- Reset with start_address=0x100, out_ready=1 -> imem_addr sequence 0x100, 0x104, 0x108; out_pc_plus4 0x104, 0x108, …; one instruction per cycle after a 2-cycle fill.
- out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, count=4, imem_req=0; release -> 4 instructions in order, no loss or duplicate.
- res_beqz=1, res_zflag=1, res_pc_plus4=0x200, res_imm=0xFFFFFFFE -> redirect=1, next imem_addr=0x1F8, old queue and in-flight data never appear on out.
- res_jump=1, res_jump_reg=1, res_reg_s1=0x4000 with out_valid && out_ready in the same cycle -> head consumed once, next fetch 0x4000; res_jump_reg=0, res_jval=0x3FFFFFC -> target 0xFFFFFFFC.
- res_bnez=1, res_nzflag=0 -> no redirect, stream uninterrupted; pc at 0xFFFFFFFC wraps to 0x0.
- Assert reset while queue full with a request in flight -> next cycle out_valid=0, count=0, fetch restarts at start_address; with BIT_REVERSE=1, address 0x4 appears as 0x20000000 on imem_addr.
